// File: rtl/prewish_mask_sequencer.sv
// Multi-channel LED mask player. Each channel shifts a double-buffered mask out
// MSB-first, one bit per shared prescaler tick, in loop or one-shot mode.
module prewish_mask_sequencer #(
    parameter int CHANNELS      = 2,
    parameter int MASK_BITS     = 8,
    parameter int MASK_CLK_BITS = 10,
    parameter int ADDR_BITS     = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 STB_I,
    input  logic [ADDR_BITS-1:0] ADR_I,
    input  logic [MASK_BITS-1:0] DAT_I,
    input  logic                 MODE_I,
    output logic                 ACK_O,
    output logic [CHANNELS-1:0]  o_led,
    output logic [CHANNELS-1:0]  o_busy
);

    // state    | meaning
    // ST_IDLE  | no pattern playing, LED dark, waiting for a pending mask
    // ST_RUN   | shifting the active mask out, one bit per tick
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int IDX_W = $clog2(MASK_BITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MASK_BITS - 1);

    logic [MASK_CLK_BITS-1:0] presc_q;
    logic [MASK_CLK_BITS-1:0] presc_d;
    logic                     tick;
    logic                     stb_q;
    logic                     ack_q;
    logic                     load_stb;
    logic                     adr_ok;
    logic                     load_ok;

    assign presc_d  = presc_q + MASK_CLK_BITS'(1);
    assign tick     = &presc_q;
    assign load_stb = STB_I & ~stb_q;
    assign adr_ok   = ({{(32-ADDR_BITS){1'b0}}, ADR_I} < 32'(CHANNELS));
    assign load_ok  = load_stb & adr_ok;
    assign ACK_O    = ack_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            presc_q <= '0;
            stb_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            stb_q   <= STB_I;
            ack_q   <= load_ok;
        end
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        state_e               state_q;
        logic [MASK_BITS-1:0] shift_q;
        logic [MASK_BITS-1:0] act_q;
        logic [MASK_BITS-1:0] pend_mask_q;
        logic [IDX_W-1:0]     idx_q;
        logic                 mode_q;
        logic                 pend_mode_q;
        logic                 pend_valid_q;
        logic                 led_q;
        logic                 load_here;
        logic                 at_end;
        logic                 consume;

        assign load_here = load_ok && (ADR_I == ADDR_BITS'(ch));
        assign at_end    = (state_q == ST_RUN) && (idx_q == IDX_LAST);
        // A pending mask is taken on a tick when idle or on the last bit of a pattern
        assign consume   = tick && pend_valid_q && ((state_q == ST_IDLE) || at_end);

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                state_q      <= ST_IDLE;
                shift_q      <= '0;
                act_q        <= '0;
                pend_mask_q  <= '0;
                idx_q        <= '0;
                mode_q       <= 1'b0;
                pend_mode_q  <= 1'b0;
                pend_valid_q <= 1'b0;
                led_q        <= 1'b0;
            end else begin
                // A load in the consuming cycle re-arms the buffer with the new mask
                if (load_here) begin
                    pend_mask_q  <= DAT_I;
                    pend_mode_q  <= MODE_I;
                    pend_valid_q <= 1'b1;
                end else if (consume) begin
                    pend_valid_q <= 1'b0;
                end

                if (consume) begin
                    state_q <= ST_RUN;
                    shift_q <= pend_mask_q;
                    act_q   <= pend_mask_q;
                    mode_q  <= pend_mode_q;
                    idx_q   <= '0;
                    led_q   <= pend_mask_q[MASK_BITS-1];
                end else if (tick && (state_q == ST_RUN)) begin
                    if (!at_end) begin
                        shift_q <= shift_q << 1;
                        idx_q   <= idx_q + IDX_W'(1);
                        led_q   <= shift_q[MASK_BITS-2];
                    end else if (mode_q) begin
                        shift_q <= act_q;
                        idx_q   <= '0;
                        led_q   <= act_q[MASK_BITS-1];
                    end else begin
                        state_q <= ST_IDLE;
                        led_q   <= 1'b0;
                    end
                end
            end
        end

        assign o_led[ch]  = led_q;
        assign o_busy[ch] = (state_q == ST_RUN);
    end

endmodule

// File: tb/tb_prewish_mask_sequencer.sv
// Bench for prewish_mask_sequencer: table of loads, per-channel queues of expected
// LED bits checked on every prescaler tick, plus reset and boundary sequences.
module tb_prewish_mask_sequencer;

    logic       clk;
    logic       rst_n;
    logic       STB_I;
    logic [1:0] ADR_I;
    logic [7:0] DAT_I;
    logic       MODE_I;
    logic       ACK_O;
    logic [1:0] o_led;
    logic [1:0] o_busy;

    prewish_mask_sequencer #(
        .CHANNELS(2), .MASK_BITS(8), .MASK_CLK_BITS(2), .ADDR_BITS(2)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .STB_I(STB_I), .ADR_I(ADR_I),
        .DAT_I(DAT_I), .MODE_I(MODE_I), .ACK_O(ACK_O),
        .o_led(o_led), .o_busy(o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] adr;
        logic [7:0] dat;
        logic       mode;
        int         hold;
        int         reps;
        logic       exp_ack;
        int         wait_q;
        logic       want_tick;
        logic       drain;
    } vec_t;

    vec_t vecs[14];

    int   n_chk = 0;
    int   n_pass = 0;
    int   ack_cnt = 0;
    int   exp_acks = 0;
    bit   mon_en = 0;
    bit   exp_q0[$];
    bit   exp_q1[$];
    logic [1:0] ph;
    logic       tick_seen;
    logic [1:0] led_prev = '0;
    logic [1:0] busy_prev = '0;

    // Bench's own view of the 2-bit prescaler: a tick edge is one where it read 3
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph        <= '0;
            tick_seen <= 1'b0;
        end else begin
            tick_seen <= (ph == 2'd3);
            ph        <= ph + 2'd1;
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    function automatic int qsize(input int c);
        return (c == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic bit qpop(input int c);
        if (c == 0) return exp_q0.pop_front();
        return exp_q1.pop_front();
    endfunction

    function automatic void qpush(input int c, input bit b);
        if (c == 0) exp_q0.push_back(b);
        else exp_q1.push_back(b);
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            for (int c = 0; c < 2; c++) begin
                if (tick_seen) begin
                    if (qsize(c) > 0) begin
                        check($sformatf("led_ch%0d", c), int'(o_led[c]), int'(qpop(c)));
                        check($sformatf("busy_ch%0d", c), int'(o_busy[c]), 1);
                    end else begin
                        check($sformatf("idle_led_ch%0d", c), int'(o_led[c]), 0);
                        check($sformatf("idle_busy_ch%0d", c), int'(o_busy[c]), 0);
                    end
                end else begin
                    check($sformatf("led_stable_ch%0d", c), int'(o_led[c]), int'(led_prev[c]));
                    check($sformatf("busy_stable_ch%0d", c), int'(o_busy[c]), int'(busy_prev[c]));
                end
            end
            if (ACK_O) ack_cnt++;
        end
        led_prev  = o_led;
        busy_prev = o_busy;
    end

    task automatic drain();
        int b = 0;
        while ((qsize(0) > 0 || qsize(1) > 0) && b < 2000) begin
            @(negedge clk);
            b++;
        end
        check("drain_bound", int'(b < 2000), 1);
        repeat (8) @(negedge clk);
    endtask

    task automatic do_load(input vec_t v);
        int b = 0;
        if (v.wait_q >= 0) begin
            while (qsize(int'(v.adr)) > v.wait_q && b < 2000) begin
                @(negedge clk);
                b++;
            end
            check("wait_q_bound", int'(b < 2000), 1);
        end
        @(negedge clk);
        while ((ph == 2'd3) != v.want_tick) @(negedge clk);
        STB_I  = 1'b1;
        ADR_I  = v.adr;
        DAT_I  = v.dat;
        MODE_I = v.mode;
        @(posedge clk);
        #1;
        for (int r = 0; r < v.reps; r++)
            for (int i = 7; i >= 0; i--) qpush(int'(v.adr), v.dat[i]);
        if (v.exp_ack) exp_acks++;
        @(negedge clk);
        check("ack", int'(ACK_O), int'(v.exp_ack));
        for (int i = 1; i < v.hold; i++) begin
            @(negedge clk);
            check("ack_hold", int'(ACK_O), 0);
        end
        STB_I = 1'b0;
        if (v.drain) drain();
    endtask

    initial begin
        vec_t v;
        //              adr    dat    mode  hold reps ack  wait_q tick  drain
        vecs[0]  = '{2'd0, 8'hA8, 1'b0, 1,  1,   1'b1, -1,    1'b0, 1'b1};
        vecs[1]  = '{2'd3, 8'hFF, 1'b1, 2,  0,   1'b0, -1,    1'b0, 1'b1};
        vecs[2]  = '{2'd2, 8'hFF, 1'b0, 1,  0,   1'b0, -1,    1'b0, 1'b1};
        vecs[3]  = '{2'd1, 8'hCA, 1'b1, 20, 2,   1'b1, -1,    1'b0, 1'b0};
        vecs[4]  = '{2'd1, 8'hF0, 1'b0, 1,  1,   1'b1, 5,     1'b0, 1'b1};
        vecs[5]  = '{2'd0, 8'h3C, 1'b0, 1,  1,   1'b1, -1,    1'b0, 1'b0};
        vecs[6]  = '{2'd0, 8'h0F, 1'b0, 1,  0,   1'b1, 6,     1'b0, 1'b0};
        vecs[7]  = '{2'd0, 8'h81, 1'b0, 1,  1,   1'b1, 4,     1'b0, 1'b1};
        vecs[8]  = '{2'd1, 8'h00, 1'b0, 1,  1,   1'b1, -1,    1'b0, 1'b1};
        vecs[9]  = '{2'd0, 8'hA5, 1'b0, 1,  1,   1'b1, -1,    1'b0, 1'b0};
        vecs[10] = '{2'd0, 8'h3C, 1'b0, 1,  1,   1'b1, 6,     1'b0, 1'b0};
        vecs[11] = '{2'd0, 8'hC3, 1'b0, 1,  1,   1'b1, 8,     1'b1, 1'b1};
        vecs[12] = '{2'd0, 8'h96, 1'b0, 1,  1,   1'b1, -1,    1'b0, 1'b0};
        vecs[13] = '{2'd1, 8'h69, 1'b0, 1,  1,   1'b1, -1,    1'b0, 1'b1};

        rst_n  = 1'b0;
        STB_I  = 1'b0;
        ADR_I  = '0;
        DAT_I  = '0;
        MODE_I = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_led", int'(o_led), 0);
        check("rst_busy", int'(o_busy), 0);
        check("rst_ack", int'(ACK_O), 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        for (int k = 0; k < 14; k++) do_load(vecs[k]);

        // Reset in the middle of a looping pattern, with a load just acknowledged
        v = '{2'd0, 8'hFF, 1'b1, 1, 1, 1'b1, -1, 1'b0, 1'b0};
        do_load(v);
        v.wait_q = 4;
        begin
            int b = 0;
            while (qsize(0) > 4 && b < 2000) begin
                @(negedge clk);
                b++;
            end
            check("rst_wait_bound", int'(b < 2000), 1);
        end
        @(negedge clk);
        check("led_before_rst", int'(o_led[0]), 1);
        mon_en = 1'b0;
        STB_I  = 1'b1;
        ADR_I  = 2'd1;
        DAT_I  = 8'h55;
        MODE_I = 1'b1;
        @(posedge clk);
        #1;
        check("ack_before_rst", int'(ACK_O), 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_led", int'(o_led), 0);
        check("async_rst_busy", int'(o_busy), 0);
        check("async_rst_ack", int'(ACK_O), 0);
        STB_I = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (48) @(negedge clk);
        v = '{2'd0, 8'h80, 1'b0, 1, 1, 1'b1, -1, 1'b0, 1'b1};
        do_load(v);

        check("ack_count", ack_cnt, exp_acks);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
